// File: rtl/riscv_pkg.sv
// ----------------------------------------------------------------------------
// riscv_pkg
// Shared definitions for the memory stage:
//   - major opcode constants (load, store, register ALU op)
//   - funct3 access-size encodings
//   - memory-stage FSM state enum
//   - helpers for byte-lane strobes and alignment checks
// ----------------------------------------------------------------------------
package riscv_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_OP    = 7'b0110011;

    // funct3[1:0] of loads and stores
    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2,
        SIZE_D = 2'd3
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } mem_state_e;

    // Contiguous lane mask for an access of the given size, anchored at lane 0.
    function automatic logic [7:0] size_strb(input mem_size_e size);
        logic [7:0] strb;
        unique case (size)
            SIZE_B:  strb = 8'h01;
            SIZE_H:  strb = 8'h03;
            SIZE_W:  strb = 8'h0F;
            SIZE_D:  strb = 8'hFF;
            default: strb = 8'h00;
        endcase
        return strb;
    endfunction

    // An access is misaligned when the byte offset is not a multiple of its size.
    function automatic logic is_misaligned(input logic [2:0] offset, input mem_size_e size);
        logic mis;
        unique case (size)
            SIZE_B:  mis = 1'b0;
            SIZE_H:  mis = offset[0];
            SIZE_W:  mis = |offset[1:0];
            SIZE_D:  mis = |offset[2:0];
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// ----------------------------------------------------------------------------
// mem_load_align
// Combinational load formatter: picks the addressed lane out of a memory word
// and sign- or zero-extends it to the full datapath width.
// Ports:
//   i_rdata     word returned by data memory
//   i_offset    byte offset of the access inside the word
//   i_size      access size (B/H/W/D)
//   i_unsigned  1 = zero-extend, 0 = sign-extend
//   o_result    formatted load value
// ----------------------------------------------------------------------------
module mem_load_align
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN     = 64,
    parameter int unsigned ADDR_LSB = 3
) (
    input  logic [XLEN-1:0]     i_rdata,
    input  logic [ADDR_LSB-1:0] i_offset,
    input  mem_size_e           i_size,
    input  logic                i_unsigned,
    output logic [XLEN-1:0]     o_result
);

    logic [XLEN-1:0] w_shifted;

    // Move the addressed lane down to bit 0 so extension works from a fixed position.
    assign w_shifted = i_rdata >> {i_offset, 3'b000};

    always_comb begin
        o_result = '0;
        unique case (i_size)
            SIZE_B: o_result = i_unsigned ? {{(XLEN-8){1'b0}}, w_shifted[7:0]}
                                          : {{(XLEN-8){w_shifted[7]}}, w_shifted[7:0]};
            SIZE_H: o_result = i_unsigned ? {{(XLEN-16){1'b0}}, w_shifted[15:0]}
                                          : {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
            SIZE_W: o_result = i_unsigned ? {{(XLEN-32){1'b0}}, w_shifted[31:0]}
                                          : {{(XLEN-32){w_shifted[31]}}, w_shifted[31:0]};
            SIZE_D: o_result = w_shifted;
            default: o_result = '0;
        endcase
    end

endmodule

// File: rtl/memory_stage.sv
// ----------------------------------------------------------------------------
// memory_stage
// Pipeline memory stage. Aligned loads/stores run a three-state handshake
// (IDLE -> ACCESS -> RESP) with data memory while stalling the upstream
// register; misaligned accesses and non-memory ops retire in one cycle.
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   mem_V, mem_PC, mem_IR        instruction in this stage
//   mem_ALU_RESULT               ALU result / effective address
//   mem_SR1, mem_SR2             source operands (SR2 = store data)
//   mem_CSRFD, mem_RFD           CSR fields, passed through
//   mem_stall                    holds the execute-to-memory register
//   dmem_req/we/addr/wdata/wstrb data-memory request (registered)
//   dmem_ready, dmem_rdata       data-memory completion and read word
//   wb_*                         writeback pipeline register
// ----------------------------------------------------------------------------
module memory_stage
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN     = 64,
    parameter int unsigned ADDR_LSB = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                mem_V,
    input  logic [XLEN-1:0]     mem_PC,
    input  logic [31:0]         mem_IR,
    input  logic [XLEN-1:0]     mem_ALU_RESULT,
    input  logic [XLEN-1:0]     mem_SR1,
    input  logic [XLEN-1:0]     mem_SR2,
    input  logic [XLEN-1:0]     mem_CSRFD,
    input  logic [XLEN-1:0]     mem_RFD,
    output logic                mem_stall,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic [XLEN-1:0]     dmem_addr,
    output logic [XLEN-1:0]     dmem_wdata,
    output logic [XLEN/8-1:0]   dmem_wstrb,
    input  logic                dmem_ready,
    input  logic [XLEN-1:0]     dmem_rdata,
    output logic                wb_V,
    output logic                wb_EXC,
    output logic [XLEN-1:0]     wb_PC,
    output logic [31:0]         wb_IR,
    output logic [XLEN-1:0]     wb_RESULT,
    output logic [XLEN-1:0]     wb_CSRFD,
    output logic [XLEN-1:0]     wb_RFD
);

    localparam int unsigned STRB_W = XLEN / 8;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [6:0]          w_opcode;
    logic [2:0]          w_funct3;
    mem_size_e           w_size;
    logic [ADDR_LSB-1:0] w_offset;
    logic                w_is_load;
    logic                w_is_store;
    logic                w_is_mem;
    logic                w_misaligned;
    logic                w_mem_go;
    logic [XLEN-1:0]     w_addr;
    logic [XLEN-1:0]     w_wdata;
    logic [STRB_W-1:0]   w_wstrb;
    logic [XLEN-1:0]     w_load_result;
    logic                w_unused_sr1;

    assign w_opcode     = mem_IR[6:0];
    assign w_funct3     = mem_IR[14:12];
    assign w_size       = mem_size_e'(w_funct3[1:0]);
    assign w_offset     = mem_ALU_RESULT[ADDR_LSB-1:0];
    assign w_is_load    = mem_V && (w_opcode == OPC_LOAD);
    assign w_is_store   = mem_V && (w_opcode == OPC_STORE);
    assign w_is_mem     = w_is_load || w_is_store;
    assign w_misaligned = w_is_mem && is_misaligned(w_offset, w_size);
    assign w_mem_go     = w_is_mem && !w_misaligned;

    assign w_addr  = {mem_ALU_RESULT[XLEN-1:ADDR_LSB], {ADDR_LSB{1'b0}}};
    assign w_wdata = mem_SR2 << {w_offset, 3'b000};
    assign w_wstrb = STRB_W'(size_strb(w_size)) << w_offset;

    // SR1 has no role in the memory stage; it is carried only for interface symmetry.
    assign w_unused_sr1 = ^mem_SR1;

    // ------------------------------------------------------------------
    // Load formatting (operates on the captured read word in RESP; the
    // instruction fields stay valid because the upstream register is held)
    // ------------------------------------------------------------------
    logic [XLEN-1:0] r_rdata;

    mem_load_align #(
        .XLEN     (XLEN),
        .ADDR_LSB (ADDR_LSB)
    ) u_load_align (
        .i_rdata    (r_rdata),
        .i_offset   (w_offset),
        .i_size     (w_size),
        .i_unsigned (w_funct3[2]),
        .o_result   (w_load_result)
    );

    // ------------------------------------------------------------------
    // FSM and registered outputs
    // ------------------------------------------------------------------
    mem_state_e        r_state;
    logic              r_dmem_req;
    logic              r_dmem_we;
    logic [XLEN-1:0]   r_dmem_addr;
    logic [XLEN-1:0]   r_dmem_wdata;
    logic [STRB_W-1:0] r_dmem_wstrb;
    logic              r_wb_v;
    logic              r_wb_exc;
    logic [XLEN-1:0]   r_wb_pc;
    logic [31:0]       r_wb_ir;
    logic [XLEN-1:0]   r_wb_result;
    logic [XLEN-1:0]   r_wb_csrfd;
    logic [XLEN-1:0]   r_wb_rfd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_dmem_req   <= 1'b0;
            r_dmem_we    <= 1'b0;
            r_dmem_addr  <= '0;
            r_dmem_wdata <= '0;
            r_dmem_wstrb <= '0;
            r_rdata      <= '0;
            r_wb_v       <= 1'b0;
            r_wb_exc     <= 1'b0;
            r_wb_pc      <= '0;
            r_wb_ir      <= '0;
            r_wb_result  <= '0;
            r_wb_csrfd   <= '0;
            r_wb_rfd     <= '0;
        end else begin
            // Bubble unless a state below retires an instruction this edge.
            r_wb_v <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_mem_go) begin
                        r_state      <= ACCESS;
                        r_dmem_req   <= 1'b1;
                        r_dmem_we    <= w_is_store;
                        r_dmem_addr  <= w_addr;
                        r_dmem_wdata <= w_is_store ? w_wdata : '0;
                        r_dmem_wstrb <= w_wstrb;
                    end else begin
                        // Non-memory ops, misaligned accesses and empty slots.
                        r_wb_v      <= mem_V;
                        r_wb_exc    <= w_misaligned;
                        r_wb_pc     <= mem_PC;
                        r_wb_ir     <= mem_IR;
                        r_wb_result <= mem_ALU_RESULT;
                        r_wb_csrfd  <= mem_CSRFD;
                        r_wb_rfd    <= mem_RFD;
                    end
                end
                ACCESS: begin
                    if (dmem_ready) begin
                        r_state      <= RESP;
                        r_rdata      <= dmem_rdata;
                        r_dmem_req   <= 1'b0;
                        r_dmem_we    <= 1'b0;
                        r_dmem_wstrb <= '0;
                    end
                end
                RESP: begin
                    r_state     <= IDLE;
                    r_wb_v      <= 1'b1;
                    r_wb_exc    <= 1'b0;
                    r_wb_pc     <= mem_PC;
                    r_wb_ir     <= mem_IR;
                    r_wb_result <= w_is_load ? w_load_result : mem_ALU_RESULT;
                    r_wb_csrfd  <= mem_CSRFD;
                    r_wb_rfd    <= mem_RFD;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Stall is combinational in IDLE so the op is held on the very cycle it arrives;
    // gating with rst_n makes it drop immediately when reset is asserted.
    assign mem_stall = rst_n && (((r_state == IDLE) && w_mem_go) || (r_state == ACCESS));

    assign dmem_req   = r_dmem_req;
    assign dmem_we    = r_dmem_we;
    assign dmem_addr  = r_dmem_addr;
    assign dmem_wdata = r_dmem_wdata;
    assign dmem_wstrb = r_dmem_wstrb;

    assign wb_V      = r_wb_v;
    assign wb_EXC    = r_wb_exc;
    assign wb_PC     = r_wb_pc;
    assign wb_IR     = r_wb_ir;
    assign wb_RESULT = r_wb_result;
    assign wb_CSRFD  = r_wb_csrfd;
    assign wb_RFD    = r_wb_rfd;

endmodule
